stream_buffer_ctrl: RTL and testbench

Controller that sits in front of the 8-entry small FIFO in the UART stream-buffer path. It arbitrates two byte producers into the FIFO's append port: the UART receiver, which cannot be stalled, and a local message source that uses a req/ack handshake. It also drains the FIFO head into the UART transmitter, one byte per TX frame. It guarantees that append and shift are never issued in the same cycle, and it keeps overflow statistics.

---
 rtl/stream_ctrl_pkg.sv | 7 +
 rtl/stream_drain_fsm.sv | 45 ++++
 rtl/stream_buffer_ctrl.sv | 93 +++++++++
 tb/tb_stream_buffer_ctrl.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_ctrl_pkg.sv
// stream_ctrl_pkg: shared types, drain states and sizing defaults for the stream buffer controller.
package stream_ctrl_pkg;
    localparam int BUFFER_SIZE_DEF = 8;
    localparam int RESERVE_DEF     = 2;
    typedef logic [7:0] byte_t;
    typedef enum logic [1:0] {IDLE, START, BUSY, GAP} drain_state_e;
endpackage

// File: rtl/stream_drain_fsm.sv
// stream_drain_fsm: pops the FIFO head into the UART transmitter, one byte per TX frame.
module stream_drain_fsm
    import stream_ctrl_pkg::*;
(
    input  logic  i_Clk,
    input  logic  i_Rst_L,
    input  logic  i_Append_Pend,
    input  logic  i_Ready_To_Read,
    input  logic  i_TX_Active,
    input  logic  i_TX_Done,
    input  byte_t i_FIFO_Head,
    output logic  o_TX_DV,
    output logic  o_Shift_Now,
    output byte_t o_TX_Byte
);
    drain_state_e state_q, state_d;
    byte_t tx_byte_q, tx_byte_d;
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q   <= IDLE;
            tx_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_byte_q <= tx_byte_d;
        end
    end
    // A pending append blocks the start so append and shift never share a cycle.
    always_comb begin
        state_d   = state_q;
        tx_byte_d = tx_byte_q;
        case (state_q)
            IDLE: begin
                state_d   = (i_Ready_To_Read && !i_TX_Active && !i_Append_Pend) ? START : IDLE;
                tx_byte_d = (state_d == START) ? i_FIFO_Head : tx_byte_q;
            end
            START:   state_d = BUSY;
            BUSY:    state_d = i_TX_Done ? GAP : BUSY;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign o_TX_DV     = state_q == START;
    assign o_Shift_Now = state_q == START;
    assign o_TX_Byte   = tx_byte_q;
endmodule

// File: rtl/stream_buffer_ctrl.sv
// stream_buffer_ctrl: arbitrates UART RX and a local source into the FIFO and drains it to UART TX.
// Define STREAM_CTRL_STATS_EN to build the overflow counter and the almost-full flag.
module stream_buffer_ctrl
    import stream_ctrl_pkg::*;
#(
    parameter int BUFFER_SIZE = BUFFER_SIZE_DEF,
    parameter int RESERVE     = RESERVE_DEF
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_A_DV,
    input  byte_t      i_A_Byte,
    output logic       o_A_Drop,
    input  logic       i_B_Req,
    input  byte_t      i_B_Byte,
    output logic       o_B_Ack,
    output logic       o_Append_Now,
    output byte_t      o_FIFO_Byte,
    output logic       o_Shift_Now,
    input  byte_t      i_FIFO_Head,
    input  logic       i_Ready_To_Read,
    input  logic [3:0] i_Free_Space,
    output logic       o_TX_DV,
    output byte_t      o_TX_Byte,
    input  logic       i_TX_Active,
    input  logic       i_TX_Done,
    output logic       o_Almost_Full,
    output logic [7:0] o_Overflow_Count
);
    localparam logic [3:0] SIZE = 4'(BUFFER_SIZE);
    localparam logic [3:0] RES  = 4'(RESERVE);
    logic append_q, append_d, ack_q, ack_d, drop_q, drop_d, grant_a, grant_b;
    byte_t fifo_byte_q, fifo_byte_d;
    logic [3:0] free, eff;
    // The FIFO count lags one cycle, so last cycle's append is still counted as free.
    assign free = i_Free_Space > SIZE ? SIZE : i_Free_Space;
    assign eff  = free > {3'b0, append_q} ? free - {3'b0, append_q} : 4'd0;
    always_comb begin
        grant_a     = i_A_DV && eff != 4'd0;
        grant_b     = i_B_Req && !i_A_DV && !ack_q && eff > RES;
        drop_d      = i_A_DV && eff == 4'd0;
        append_d    = grant_a || grant_b;
        ack_d       = grant_b;
        fifo_byte_d = grant_a ? i_A_Byte : grant_b ? i_B_Byte : fifo_byte_q;
    end
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            append_q    <= 1'b0;
            ack_q       <= 1'b0;
            drop_q      <= 1'b0;
            fifo_byte_q <= '0;
        end else begin
            append_q    <= append_d;
            ack_q       <= ack_d;
            drop_q      <= drop_d;
            fifo_byte_q <= fifo_byte_d;
        end
    end
    assign o_Append_Now = append_q;
    assign o_B_Ack      = ack_q;
    assign o_A_Drop     = drop_q;
    assign o_FIFO_Byte  = fifo_byte_q;
    stream_drain_fsm u_drain (
        .i_Clk           (i_Clk),
        .i_Rst_L         (i_Rst_L),
        .i_Append_Pend   (append_d),
        .i_Ready_To_Read (i_Ready_To_Read),
        .i_TX_Active     (i_TX_Active),
        .i_TX_Done       (i_TX_Done),
        .i_FIFO_Head     (i_FIFO_Head),
        .o_TX_DV         (o_TX_DV),
        .o_Shift_Now     (o_Shift_Now),
        .o_TX_Byte       (o_TX_Byte)
    );
`ifdef STREAM_CTRL_STATS_EN
    logic [7:0] ovf_q;
    logic almost_q;
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            ovf_q    <= '0;
            almost_q <= 1'b0;
        end else begin
            ovf_q    <= (drop_d && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;
            almost_q <= eff <= RES;
        end
    end
    assign o_Overflow_Count = ovf_q;
    assign o_Almost_Full    = almost_q;
`else
    assign o_Overflow_Count = '0;
    assign o_Almost_Full    = 1'b0;
`endif
endmodule

// File: tb/tb_stream_buffer_ctrl.sv
// tb_stream_buffer_ctrl: directed and randomized checks of stream_buffer_ctrl against a FIFO/TX
// environment model, a per-cycle arbitration reference and an in-order byte scoreboard.
module tb_stream_buffer_ctrl;
    import stream_ctrl_pkg::*;
    logic clk = 1'b0, rst_l = 1'b0;
    logic a_dv = 1'b0, b_req = 1'b0;
    byte_t a_byte = '0, b_byte = '0;
    logic use_model = 1'b0, d_ready = 1'b0, d_active = 1'b0, d_done = 1'b0;
    logic [3:0] d_free = 4'd8;
    byte_t d_head = '0;
    logic [3:0] m_free = 4'd8;
    logic m_ready = 1'b0, m_active = 1'b0, m_done = 1'b0;
    byte_t m_head = '0;
    logic [3:0] free;
    logic ready, active, done;
    byte_t head;
    logic o_A_Drop, o_B_Ack, o_Append_Now, o_Shift_Now, o_TX_DV, o_Almost_Full;
    byte_t o_FIFO_Byte, o_TX_Byte;
    logic [7:0] o_Overflow_Count;
    int checks = 0, fails = 0, cyc = 0;

    assign free   = use_model ? m_free : d_free;
    assign ready  = use_model ? m_ready : d_ready;
    assign head   = use_model ? m_head : d_head;
    assign active = m_active | d_active;
    assign done   = m_done | d_done;

    stream_buffer_ctrl dut (
        .i_Clk(clk), .i_Rst_L(rst_l),
        .i_A_DV(a_dv), .i_A_Byte(a_byte), .o_A_Drop(o_A_Drop),
        .i_B_Req(b_req), .i_B_Byte(b_byte), .o_B_Ack(o_B_Ack),
        .o_Append_Now(o_Append_Now), .o_FIFO_Byte(o_FIFO_Byte), .o_Shift_Now(o_Shift_Now),
        .i_FIFO_Head(head), .i_Ready_To_Read(ready), .i_Free_Space(free),
        .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte), .i_TX_Active(active), .i_TX_Done(done),
        .o_Almost_Full(o_Almost_Full), .o_Overflow_Count(o_Overflow_Count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // 8-entry FIFO environment: registered count/head, like the real FIFO.
    byte_t fq[$];
    always @(posedge clk) begin
        if (!use_model) fq.delete();
        else begin
            if (o_Shift_Now && fq.size() > 0) void'(fq.pop_front());
            if (o_Append_Now && fq.size() < 8) fq.push_back(o_FIFO_Byte);
        end
        m_free  <= 4'(8 - fq.size());
        m_ready <= fq.size() != 0;
        m_head  <= fq.size() != 0 ? fq[0] : 8'h00;
    end

    int tx_left = 0;
    always @(posedge clk) begin
        m_done <= 1'b0;
        if (!m_active && o_TX_DV) begin
            m_active <= 1'b1;
            tx_left = 4 + int'($urandom_range(0, 3));
        end else if (m_active) begin
            tx_left--;
            if (tx_left == 0) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
            end
        end
    end

    // Reference monitor: inputs captured each negedge predict the outputs seen one cycle later.
    logic p_rst = 1'b0, p_adv = 1'b0, p_breq = 1'b0, p_app = 1'b0, p_ack = 1'b0, mon_en = 1'b0;
    byte_t p_abyte = '0, p_bbyte = '0;
    logic [3:0] p_free = '0, eff;
    logic e_a, e_b, e_d, exp_af;
    logic [7:0] exp_cnt;
    int drops_m = 0, last_done = -100;
    byte_t sb[$];
    always @(negedge clk) begin
        if (!use_model) sb.delete();
        if (mon_en && !p_rst) begin
            drops_m = 0;
            checks++;
            if ({o_Append_Now, o_A_Drop, o_B_Ack, o_Shift_Now, o_TX_DV, o_FIFO_Byte, o_TX_Byte,
                 o_Overflow_Count, o_Almost_Full} !== '0) begin
                fails++;
                $display("FAIL reset_outputs cyc=%0d: got app=%b drop=%b ack=%b shift=%b dv=%b fb=%h tb=%h cnt=%0d af=%b, required all 0",
                         cyc, o_Append_Now, o_A_Drop, o_B_Ack, o_Shift_Now, o_TX_DV, o_FIFO_Byte, o_TX_Byte, o_Overflow_Count, o_Almost_Full);
            end
        end else if (mon_en) begin
            eff = p_free > {3'b0, p_app} ? p_free - {3'b0, p_app} : 4'd0;
            e_d = p_adv && eff == 0;
            e_a = p_adv && eff != 0;
            e_b = p_breq && !p_adv && eff > 4'd2 && !p_ack;
            checks++;
            if ({o_Append_Now, o_B_Ack, o_A_Drop} !== {e_a | e_b, e_b, e_d}) begin
                fails++;
                $display("FAIL arbitration cyc=%0d: got app/ack/drop=%b%b%b, required %b%b%b",
                         cyc, o_Append_Now, o_B_Ack, o_A_Drop, e_a | e_b, e_b, e_d);
            end
            if (e_a || e_b) begin
                checks++;
                if (o_FIFO_Byte !== (e_a ? p_abyte : p_bbyte)) begin
                    fails++;
                    $display("FAIL append_byte cyc=%0d: got %h, required %h", cyc, o_FIFO_Byte, e_a ? p_abyte : p_bbyte);
                end
            end
`ifdef STREAM_CTRL_STATS_EN
            if (e_d && drops_m < 255) drops_m++;
            exp_cnt = 8'(drops_m);
            exp_af  = eff <= 4'd2;
`else
            exp_cnt = 8'd0;
            exp_af  = 1'b0;
`endif
            checks++;
            if ({o_Overflow_Count, o_Almost_Full} !== {exp_cnt, exp_af}) begin
                fails++;
                $display("FAIL stats cyc=%0d: got cnt=%0d af=%b, required cnt=%0d af=%b",
                         cyc, o_Overflow_Count, o_Almost_Full, exp_cnt, exp_af);
            end
            checks++;
            if (o_Append_Now && o_Shift_Now) begin
                fails++;
                $display("FAIL append_shift_overlap cyc=%0d: got both 1, required at most one", cyc);
            end
            if (use_model && o_Append_Now) sb.push_back(o_FIFO_Byte);
            if (o_TX_DV) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL tx_order cyc=%0d: got byte %h, required no transmit (nothing queued)", cyc, o_TX_Byte);
                end else if (o_TX_Byte !== sb[0]) begin
                    fails++;
                    $display("FAIL tx_order cyc=%0d: got %h, required %h", cyc, o_TX_Byte, sb[0]);
                end
                if (sb.size() != 0) void'(sb.pop_front());
                checks++;
                if (cyc - last_done < 2) begin
                    fails++;
                    $display("FAIL tx_gap cyc=%0d: got %0d cycles after done, required >= 2", cyc, cyc - last_done);
                end
            end
        end
        if (done) last_done = cyc;
        p_rst = rst_l; p_adv = a_dv; p_abyte = a_byte; p_breq = b_req; p_bbyte = b_byte;
        p_free = free; p_app = o_Append_Now; p_ack = o_B_Ack;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_wait();
        int quiet = 0;
        for (int i = 0; i < 400 && quiet < 3; i++) begin
            @(negedge clk);
            quiet = (m_free == 4'd8 && !m_active && !o_Append_Now && !o_TX_DV) ? quiet + 1 : 0;
        end
        checks++;
        if (quiet < 3) begin
            fails++;
            $display("FAIL drain_timeout: got FIFO free=%0d active=%b, required empty and idle", m_free, m_active);
        end
        step();
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        repeat (2) step();
        rst_l = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if ({o_Append_Now, o_A_Drop, o_B_Ack, o_Shift_Now, o_TX_DV} !== 5'b0) begin
            fails++;
            $display("FAIL reset_strobes: got %b, required 00000", {o_Append_Now, o_A_Drop, o_B_Ack, o_Shift_Now, o_TX_DV});
        end
        checks++;
        if ({o_FIFO_Byte, o_TX_Byte, o_Overflow_Count, o_Almost_Full} !== 25'b0) begin
            fails++;
            $display("FAIL reset_data: got fb=%h tb=%h cnt=%0d af=%b, required 0", o_FIFO_Byte, o_TX_Byte, o_Overflow_Count, o_Almost_Full);
        end
        checks++;
        if (dut.u_drain.state_q !== IDLE) begin
            fails++;
            $display("FAIL reset_state: got %0d, required IDLE", dut.u_drain.state_q);
        end
        step();
        rst_l = 1'b1;
        mon_en = 1'b1;
        step();
    endtask

    task automatic test_rx_to_tx();
        int t0;
        logic found = 1'b0;
        use_model = 1'b1;
        step();
        a_dv = 1'b1; a_byte = 8'h41;
        step();
        a_dv = 1'b0;
        @(negedge clk);
        t0 = cyc;
        checks++;
        if ({o_Append_Now, o_FIFO_Byte} !== {1'b1, 8'h41}) begin
            fails++;
            $display("FAIL rx_append: got app=%b byte=%h, required app=1 byte=41", o_Append_Now, o_FIFO_Byte);
        end
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = o_TX_DV;
        end
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL rx_tx_timeout: got no o_TX_DV, required one within 20 cycles");
        end else begin
            checks++;
            if ({o_TX_Byte, o_Shift_Now, o_Append_Now} !== {8'h41, 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL rx_tx_start: got byte=%h shift=%b app=%b, required 41/1/0", o_TX_Byte, o_Shift_Now, o_Append_Now);
            end
            checks++;
            if (cyc - t0 != 2) begin
                fails++;
                $display("FAIL rx_tx_latency: got %0d cycles append->dv, required 2", cyc - t0);
            end
        end
        drain_wait();
    endtask

    task automatic test_priority();
        int acks = 0;
        a_dv = 1'b1; a_byte = 8'h11; b_req = 1'b1; b_byte = 8'h22;
        step();
        a_dv = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_Append_Now, o_FIFO_Byte, o_B_Ack} !== {1'b1, 8'h11, 1'b0}) begin
            fails++;
            $display("FAIL prio_rx_first: got app=%b byte=%h ack=%b, required 1/11/0", o_Append_Now, o_FIFO_Byte, o_B_Ack);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            if (acks != 0) b_req = 1'b0;
            @(negedge clk);
            if (o_B_Ack) begin
                acks++;
                checks++;
                if ({o_Append_Now, o_FIFO_Byte} !== {1'b1, 8'h22}) begin
                    fails++;
                    $display("FAIL prio_b_byte: got app=%b byte=%h, required 1/22", o_Append_Now, o_FIFO_Byte);
                end
            end
        end
        b_req = 1'b0;
        checks++;
        if (acks != 1) begin
            fails++;
            $display("FAIL prio_b_ack_count: got %0d, required 1", acks);
        end
        drain_wait();
    endtask

    task automatic test_reserve();
        int acks = 0;
        use_model = 1'b0; d_free = 4'd2; d_ready = 1'b0;
        step();
        b_req = 1'b1; b_byte = 8'h77;
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clk);
            if (o_B_Ack) acks++;
        end
        checks++;
        if (o_Almost_Full !== (`ifdef STREAM_CTRL_STATS_EN 1'b1 `else 1'b0 `endif)) begin
            fails++;
            $display("FAIL reserve_almost_full: got %b", o_Almost_Full);
        end
        step();
        a_dv = 1'b1; a_byte = 8'h33;
        step();
        a_dv = 1'b0;
        @(negedge clk);
        if (o_B_Ack) acks++;
        checks++;
        if ({o_Append_Now, o_FIFO_Byte} !== {1'b1, 8'h33}) begin
            fails++;
            $display("FAIL reserve_rx_append: got app=%b byte=%h, required 1/33", o_Append_Now, o_FIFO_Byte);
        end
        b_req = 1'b0;
        checks++;
        if (acks != 0) begin
            fails++;
            $display("FAIL reserve_b_ack: got %0d acks, required 0", acks);
        end
        step();
    endtask

    task automatic test_overflow();
        int drops = 0, apps = 0;
        d_free = 4'd0;
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            a_dv = (i < 6) && (i % 2 == 0);
            a_byte = 8'(i);
            @(negedge clk);
            drops += int'(o_A_Drop);
            apps += int'(o_Append_Now);
        end
        checks++;
        if (drops != 3 || apps != 0) begin
            fails++;
            $display("FAIL overflow_pulses: got drops=%0d appends=%0d, required 3/0", drops, apps);
        end
        checks++;
        if (o_Overflow_Count !== (`ifdef STREAM_CTRL_STATS_EN 8'd3 `else 8'd0 `endif)) begin
            fails++;
            $display("FAIL overflow_count: got %0d", o_Overflow_Count);
        end
        step();
        a_dv = 1'b1;
        repeat (260) step();
        a_dv = 1'b0;
        repeat (2) step();
        @(negedge clk);
        checks++;
        if (o_Overflow_Count !== (`ifdef STREAM_CTRL_STATS_EN 8'd255 `else 8'd0 `endif)) begin
            fails++;
            $display("FAIL overflow_saturate: got %0d", o_Overflow_Count);
        end
        d_free = 4'd8;
        step();
    endtask

    task automatic test_drain_order();
        int got = 0, ld = -100;
        use_model = 1'b1; d_active = 1'b1;
        step();
        for (int i = 1; i <= 8; i++) begin
            a_dv = 1'b1; a_byte = 8'(i);
            step();
            a_dv = 1'b0;
            step();
        end
        step();
        @(negedge clk);
        checks++;
        if (m_free !== 4'd0 || o_TX_DV) begin
            fails++;
            $display("FAIL drain_fill: got free=%0d dv=%b, required free=0 dv=0", m_free, o_TX_DV);
        end
        step();
        d_active = 1'b0;
        for (int i = 0; i < 500 && got < 8; i++) begin
            @(negedge clk);
            if (done) ld = cyc;
            if (o_TX_DV) begin
                checks++;
                if (o_TX_Byte !== 8'(got + 1)) begin
                    fails++;
                    $display("FAIL drain_seq: got %h, required %h", o_TX_Byte, 8'(got + 1));
                end
                if (got > 0) begin
                    checks++;
                    if (cyc - ld < 2) begin
                        fails++;
                        $display("FAIL drain_gap: got %0d, required >= 2", cyc - ld);
                    end
                end
                got++;
            end
        end
        checks++;
        if (got != 8) begin
            fails++;
            $display("FAIL drain_count: got %0d frames, required 8", got);
        end
        drain_wait();
    endtask

    task automatic test_reset_midframe();
        logic found = 1'b0;
        int strays = 0;
        a_dv = 1'b1; a_byte = 8'h5A;
        step();
        a_dv = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = o_TX_DV;
        end
        step();
        rst_l = 1'b0;
        step();
        rst_l = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_Append_Now, o_A_Drop, o_B_Ack, o_Shift_Now, o_TX_DV, o_TX_Byte} !== 13'b0) begin
            fails++;
            $display("FAIL midreset_outputs: got dv=%b shift=%b tb=%h, required 0", o_TX_DV, o_Shift_Now, o_TX_Byte);
        end
        checks++;
        if (!found || dut.u_drain.state_q !== IDLE) begin
            fails++;
            $display("FAIL midreset_state: got frame_started=%b state=%0d, required 1/IDLE", found, dut.u_drain.state_q);
        end
        for (int i = 0; i < 20 && !m_done; i++) @(negedge clk);
        step();
        d_done = 1'b1;
        step();
        d_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            strays += int'(o_Shift_Now | o_TX_DV);
        end
        checks++;
        if (strays != 0 || dut.u_drain.state_q !== IDLE) begin
            fails++;
            $display("FAIL stray_done: got %0d shifts state=%0d, required 0/IDLE", strays, dut.u_drain.state_q);
        end
        step();
    endtask

    task automatic test_random();
        logic acked = 1'b0;
        use_model = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            step();
            if (acked) b_req = 1'b0;
            else if (!b_req && $urandom_range(0, 2) == 0) begin
                b_req = 1'b1;
                b_byte = 8'($urandom);
            end
            a_dv = $urandom_range(0, 3) == 0;
            a_byte = 8'($urandom);
            @(negedge clk);
            acked = o_B_Ack;
        end
        step();
        a_dv = 1'b0; b_req = 1'b0;
        drain_wait();
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL random_leftover: got %0d bytes never transmitted, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_rx_to_tx();
        test_priority();
        test_reserve();
        test_overflow();
        do_reset();
        test_drain_order();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
